mem_access_unit: RTL and testbench

- Sits directly downstream of the pipeline's memory stage and upstream of the data RAM/bus.
- Takes the M-stage access request (address, store data, size, sign, read/write) and performs one bus transaction under a req/ack handshake.
- Generates byte enables and lane-replicated store data, and returns aligned, sign- or zero-extended load data.
- Holds the pipeline via mem_stall_o while the transaction is outstanding.

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/mem_load_ext.sv | 33 +++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory access unit: size codes, FSM states,
// byte-enable constants and the alignment/lane helpers used by the top level.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reserved size 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? BE_HI : BE_LO;
            default: return BE_ALL;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load formatter: picks the addressed byte/half lane out of a bus word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[7:0];
        case (lo)
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            2'd3:    sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        sel_half = lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: result = sign ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
            SZ_HALF: result = sign ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage to bus bridge: one req/ack transaction per access, with lane steering and a
// REQ-cycle timeout. Define MEM_MISALIGN_EXC_EN to trap misaligned accesses instead of masking.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_sign_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_stall_o,
    output logic              bus_err_o,
    output logic              addr_err_o,
    output logic [ADDR_W-1:0] bad_addr_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic             sign_q;
    logic [1:0]       lo_q;
    logic [1:0]       lo_aligned;
    logic             accept;
    logic             timeout;
    logic [31:0]      load_result;

    assign lo_aligned = align_lo(mem_size_i, mem_addr_i[1:0]);

`ifdef MEM_MISALIGN_EXC_EN
    logic misaligned;
    assign misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);
    assign accept     = mem_req_i && !misaligned;
    assign addr_err_o = (state == IDLE) && mem_req_i && misaligned;
    assign bad_addr_o = addr_err_o ? mem_addr_i : '0;
`else
    assign accept     = mem_req_i;
    assign addr_err_o = 1'b0;
    assign bad_addr_o = '0;
`endif

    // Timeout fires on the BUS_TIMEOUT-th consecutive REQ cycle that sees no ack.
    generate
        if (BUS_TIMEOUT != 0) begin : g_timeout
            assign timeout = !bus_ack_i && (cnt == CNT_W'(BUS_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    mem_load_ext u_load_ext (
        .rdata  (bus_rdata_i),
        .lo     (lo_q),
        .size   (size_q),
        .sign   (sign_q),
        .result (load_result)
    );

    assign bus_req_o = (state == REQ);

    always_comb begin
        state_next  = state;
        mem_stall_o = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    mem_stall_o = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                mem_stall_o = 1'b1;
                if (bus_ack_i || timeout) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            mem_rdata_o <= '0;
            bus_err_o   <= 1'b0;
            size_q      <= SZ_BYTE;
            sign_q      <= 1'b0;
            lo_q        <= 2'b00;
        end else begin
            state     <= state_next;
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        bus_be_o    <= byte_enable(mem_size_i, lo_aligned);
                        bus_wdata_o <= lane_data(mem_size_i, mem_wdata_i);
                        bus_we_o    <= mem_we_i;
                        size_q      <= mem_size_i;
                        sign_q      <= mem_sign_i;
                        lo_q        <= lo_aligned;
                        cnt         <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack_i) begin
                        if (!bus_we_o) mem_rdata_o <= load_result;
                    end else if (timeout) begin
                        bus_err_o   <= 1'b1;
                        mem_rdata_o <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, lane steering, misalignment,
// timeout abort and reset mid-transaction. Honors MEM_MISALIGN_EXC_EN when defined.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req_i, mem_we_i, mem_sign_i;
    logic [1:0]        mem_size_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_stall_o, bus_err_o, addr_err_o;
    logic [ADDR_W-1:0] bad_addr_o;
    logic              bus_req_o, bus_we_o;
    logic [3:0]        bus_be_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_ack_i;
    logic [31:0]       bus_rdata_i;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    // Observations from the most recent access.
    int          stall_cycles, req_cycles;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_we, bus_stable, done_err, first_addr_err;
    logic [31:0] done_rdata, first_bad_addr;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .BUS_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_size_i  (mem_size_i),
        .mem_sign_i  (mem_sign_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_stall_o (mem_stall_o),
        .bus_err_o   (bus_err_o),
        .addr_err_o  (addr_err_o),
        .bad_addr_o  (bad_addr_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_be_o    (bus_be_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    // Driver: presents one access, acks on REQ cycle ack_on (0 = never), ends in DONE.
    task automatic run_access(input logic we, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_on, input logic [31:0] rdata);
        int cyc;
        logic expired;
        @(negedge clk);
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_size_i  = size;
        mem_sign_i  = sign;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        stall_cycles = 0;
        req_cycles   = 0;
        bus_stable   = 1'b1;
        cyc          = 0;
        expired      = 1'b0;
        #1;
        first_addr_err = addr_err_o;
        first_bad_addr = bad_addr_o;
        while (mem_stall_o && !expired) begin
            stall_cycles++;
            if (bus_req_o) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    req_addr  = bus_addr_o;
                    req_be    = bus_be_o;
                    req_wdata = bus_wdata_o;
                    req_we    = bus_we_o;
                end else if ({bus_addr_o, bus_be_o, bus_wdata_o, bus_we_o} !==
                             {req_addr, req_be, req_wdata, req_we}) begin
                    bus_stable = 1'b0;
                end
                if (req_cycles == ack_on) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = rdata;
                end
            end
            @(negedge clk);
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'h0;
            #1;
            cyc++;
            if (cyc > 40) expired = 1'b1;
        end
        done_err   = bus_err_o;
        done_rdata = mem_rdata_o;
        mem_req_i  = 1'b0;
        checks++;
        if (expired) begin
            failures++;
            $display("FAIL access_bound got=stall_after_40_cycles exp=released addr=%h", addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || mem_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_ctrl got=req%b we%b stall%b exp=000", bus_req_o, bus_we_o, mem_stall_o);
        end
        checks++;
        if (bus_be_o !== 4'h0 || bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_bus got=%h/%h/%h exp=0/0/0", bus_be_o, bus_addr_o, bus_wdata_o);
        end
        checks++;
        if (mem_rdata_o !== 32'h0 || bus_err_o !== 1'b0 || addr_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_data got=%h err%b aerr%b exp=0", mem_rdata_o, bus_err_o, addr_err_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        run_access(1'b1, SZ_WORD, 1'b0, 32'h104, 32'hDEADBEEF, 2, 32'h0);
        checks++;
        if (req_addr !== 32'h104 || req_be !== 4'b1111 || req_we !== 1'b1) begin
            failures++;
            $display("FAIL sw_bus got=%h/%b/%b exp=00000104/1111/1", req_addr, req_be, req_we);
        end
        checks++;
        if (req_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_wdata got=%h exp=deadbeef", req_wdata);
        end
        checks++;
        if (stall_cycles !== 3) begin
            failures++;
            $display("FAIL sw_stall got=%0d exp=3", stall_cycles);
        end
        checks++;
        if (bus_stable !== 1'b1) begin
            failures++;
            $display("FAIL sw_stable got=%b exp=1", bus_stable);
        end
        checks++;
        if (done_rdata !== 32'h0 || done_err !== 1'b0) begin
            failures++;
            $display("FAIL sw_rdata got=%h err%b exp=00000000 err0", done_rdata, done_err);
        end
    endtask

    task automatic test_load_byte();
        exp_q.push_back(32'hFFFFFF80);
        exp_q.push_back(32'h00000080);
        for (int s = 1; s >= 0; s--) begin
            run_access(1'b0, SZ_BYTE, s[0], 32'h103, 32'h0, 1, 32'h80FF1234);
            exp_v = exp_q.pop_front();
            checks++;
            if (done_rdata !== exp_v) begin
                failures++;
                $display("FAIL lb_data sign=%0d got=%h exp=%h", s, done_rdata, exp_v);
            end
            checks++;
            if (stall_cycles !== 2 || req_be !== 4'b1000 || req_addr !== 32'h100) begin
                failures++;
                $display("FAIL lb_bus got=stall%0d be%b addr%h exp=stall2 be1000 addr00000100",
                         stall_cycles, req_be, req_addr);
            end
        end
    endtask

    task automatic test_load_half();
        run_access(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 1, 32'h80017FFF);
        checks++;
        if (done_rdata !== 32'hFFFF8001 || req_be !== 4'b1100) begin
            failures++;
            $display("FAIL lh_hi got=%h be%b exp=ffff8001 be1100", done_rdata, req_be);
        end
        run_access(1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0, 1, 32'h80017FFF);
        checks++;
        if (done_rdata !== 32'h00007FFF || req_be !== 4'b0011) begin
            failures++;
            $display("FAIL lhu_lo got=%h be%b exp=00007fff be0011", done_rdata, req_be);
        end
    endtask

    task automatic test_store_narrow();
        run_access(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h000000AB, 1, 32'h0);
        checks++;
        if (req_be !== 4'b0010 || req_wdata !== 32'hABABABAB || req_addr !== 32'h100) begin
            failures++;
            $display("FAIL sb_bus got=%b/%h/%h exp=0010/abababab/00000100", req_be, req_wdata, req_addr);
        end
        checks++;
        if (done_rdata !== 32'h00007FFF) begin
            failures++;
            $display("FAIL sb_hold got=%h exp=00007fff", done_rdata);
        end
        run_access(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h1234CAFE, 1, 32'h0);
        checks++;
        if (req_be !== 4'b1100 || req_wdata !== 32'hCAFECAFE) begin
            failures++;
            $display("FAIL sh_bus got=%b/%h exp=1100/cafecafe", req_be, req_wdata);
        end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, SZ_WORD, 1'b0, 32'h106, 32'h0, 1, 32'h11223344);
`ifdef MEM_MISALIGN_EXC_EN
        checks++;
        if (first_addr_err !== 1'b1 || first_bad_addr !== 32'h106) begin
            failures++;
            $display("FAIL lw_mis_err got=%b/%h exp=1/00000106", first_addr_err, first_bad_addr);
        end
        checks++;
        if (stall_cycles !== 0) begin
            failures++;
            $display("FAIL lw_mis_stall got=%0d exp=0", stall_cycles);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus_req_o !== 1'b0 || addr_err_o !== 1'b0) begin
            failures++;
            $display("FAIL lw_mis_nobus got=req%b aerr%b exp=00", bus_req_o, addr_err_o);
        end
`else
        checks++;
        if (first_addr_err !== 1'b0 || first_bad_addr !== 32'h0) begin
            failures++;
            $display("FAIL lw_mis_err got=%b/%h exp=0/00000000", first_addr_err, first_bad_addr);
        end
        checks++;
        if (req_addr !== 32'h104 || req_be !== 4'b1111 || done_rdata !== 32'h11223344) begin
            failures++;
            $display("FAIL lw_mis_bus got=%h/%b/%h exp=00000104/1111/11223344", req_addr, req_be, done_rdata);
        end
        run_access(1'b0, SZ_HALF, 1'b0, 32'h103, 32'h0, 1, 32'hABCD0000);
        checks++;
        if (req_be !== 4'b1100 || done_rdata !== 32'h0000ABCD) begin
            failures++;
            $display("FAIL lh_mis got=%b/%h exp=1100/0000abcd", req_be, done_rdata);
        end
`endif
    endtask

    task automatic test_timeout();
        run_access(1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0, 0, 32'h0);
        checks++;
        if (req_cycles !== 4 || stall_cycles !== 5) begin
            failures++;
            $display("FAIL to_len got=req%0d stall%0d exp=req4 stall5", req_cycles, stall_cycles);
        end
        checks++;
        if (done_err !== 1'b1 || done_rdata !== 32'h0) begin
            failures++;
            $display("FAIL to_abort got=err%b data%h exp=err1 data00000000", done_err, done_rdata);
        end
        @(negedge clk);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h5A5A5A5A;
        #1;
        checks++;
        if (bus_err_o !== 1'b0 || mem_stall_o !== 1'b0 || bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL to_after got=err%b stall%b req%b exp=000", bus_err_o, mem_stall_o, bus_req_o);
        end
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        #1;
        checks++;
        if (mem_rdata_o !== 32'h0 || bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL to_late_ack got=%h req%b exp=00000000 req0", mem_rdata_o, bus_req_o);
        end
    endtask

    task automatic test_reset_mid();
        run_access(1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0, 1, 32'h13579BDF);
        @(negedge clk);
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_size_i = SZ_WORD;
        mem_addr_i = 32'h304;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rm_inreq got=%b exp=1", bus_req_o);
        end
        rst       = 1'b1;
        mem_req_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req_o !== 1'b0 || mem_stall_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rm_abort got=req%b stall%b data%h exp=0/0/00000000", bus_req_o, mem_stall_o, mem_rdata_o);
        end
        rst         = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        #1;
        checks++;
        if (bus_req_o !== 1'b0 || mem_stall_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rm_late_ack got=req%b stall%b data%h exp=0/0/00000000", bus_req_o, mem_stall_o, mem_rdata_o);
        end
        run_access(1'b0, SZ_BYTE, 1'b0, 32'h100, 32'h0, 1, 32'h000000C3);
        checks++;
        if (done_rdata !== 32'h000000C3 || stall_cycles !== 2) begin
            failures++;
            $display("FAIL rm_recover got=%h stall%0d exp=000000c3 stall2", done_rdata, stall_cycles);
        end
    endtask

    initial begin
        rst         = 1'b1;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_size_i  = SZ_BYTE;
        mem_sign_i  = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;

        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half();
        test_store_narrow();
        test_misaligned();
        test_timeout();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
